// File: rtl/serial_arith_defs.sv
// Shared definitions for the bit-serial adder/subtractor datapaths:
// FSM state encodings and the default operand width used by their benches.
package serial_arith_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int SERIAL_WIDTH = 4;

  // Width of a bit counter that must reach w without wrapping
  function automatic int count_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_serial.sv
// Combinational one-bit subtractor cell: computes x - y - bin.
module full_subtractor_serial (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b, LSB first) with start/busy/done
// sequencing, parallel operand load and parallel result collection.
module serial_subtractor
  import serial_arith_defs::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             borrow_bit,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             done
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    count_r;
  logic             borrow_ff_r;
  logic             borrow_out_r;
  logic             busy_r;
  logic             done_r;

  logic             cell_diff_s;
  logic             cell_bout_s;
  logic             diff_bit_s;
  logic             borrow_bit_s;
  logic [WIDTH:0]   result_ext_s;

  full_subtractor_serial u_cell (
    .x    (a_sr_r[0]),
    .y    (b_sr_r[0]),
    .bin  (borrow_ff_r),
    .diff (cell_diff_s),
    .bout (cell_bout_s)
  );

  // Serial outputs only show the bit cell while shifting
  always_comb begin
    diff_bit_s   = 1'b0;
    borrow_bit_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      diff_bit_s   = cell_diff_s;
      borrow_bit_s = cell_bout_s;
    end else begin
      diff_bit_s   = 1'b0;
      borrow_bit_s = 1'b0;
    end
  end

  // New difference bit enters at the MSB; works for WIDTH == 1 as well
  assign result_ext_s = {diff_bit_s, result_r};

  // Sequencing FSM, operand shift registers, borrow FF, counter and result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      a_sr_r       <= {WIDTH{1'b0}};
      b_sr_r       <= {WIDTH{1'b0}};
      result_r     <= {WIDTH{1'b0}};
      count_r      <= {CW{1'b0}};
      borrow_ff_r  <= 1'b0;
      borrow_out_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r      <= ST_SHIFT;
            a_sr_r       <= a;
            b_sr_r       <= b;
            result_r     <= {WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            borrow_ff_r  <= 1'b0;
            borrow_out_r <= 1'b0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT: begin
          result_r    <= result_ext_s[WIDTH:1];
          borrow_ff_r <= borrow_bit_s;
          a_sr_r      <= a_sr_r >> 1;
          b_sr_r      <= b_sr_r >> 1;
          count_r     <= count_r + CNT_ONE;
          if (count_r == LAST_CNT) begin
            state_r      <= ST_DONE;
            borrow_out_r <= borrow_bit_s;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign borrow_out = borrow_out_r;
  assign diff_bit   = diff_bit_s;
  assign borrow_bit = borrow_bit_s;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         diff_bit;
  logic         borrow_bit;
  logic [W-1:0] result;
  logic         borrow_out;
  logic         done;

  int checks;
  int passed;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .diff_bit   (diff_bit),
    .borrow_bit (borrow_bit),
    .result     (result),
    .borrow_out (borrow_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (result !== 4'd0) $display("FAIL reset_result got %h want 0", result); else passed++;
    checks++; if (borrow_out !== 1'b0) $display("FAIL reset_borrow_out got %b want 0", borrow_out); else passed++;
    checks++; if (diff_bit !== 1'b0 || borrow_bit !== 1'b0)
      $display("FAIL reset_serial got %b%b want 00", diff_bit, borrow_bit); else passed++;
  endtask

  // 9 - 3: per-bit serial outputs checked against a hand-computed table
  task automatic test_bit_sequence();
    logic [3:0] exp_d;
    logic [3:0] exp_b;
    exp_d = 4'b0110;  // bit i = difference bit of cycle i
    exp_b = 4'b0110;
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; a = 4'd0; b = 4'd0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1) $display("FAIL seq_busy[%0d] got %b want 1", i, busy); else passed++;
      checks++; if (diff_bit !== exp_d[i]) $display("FAIL seq_diff[%0d] got %b want %b", i, diff_bit, exp_d[i]); else passed++;
      checks++; if (borrow_bit !== exp_b[i]) $display("FAIL seq_borrow[%0d] got %b want %b", i, borrow_bit, exp_b[i]); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL seq_early_done[%0d] got %b want 0", i, done); else passed++;
      tick();
    end
    checks++; if (done !== 1'b1) $display("FAIL seq_done got %b want 1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL seq_busy_end got %b want 0", busy); else passed++;
    checks++; if (result !== 4'd6) $display("FAIL seq_result got %h want 6", result); else passed++;
    checks++; if (borrow_out !== 1'b0) $display("FAIL seq_borrow_out got %b want 0", borrow_out); else passed++;
    checks++; if (diff_bit !== 1'b0) $display("FAIL seq_diff_idle got %b want 0", diff_bit); else passed++;
  endtask

  // One full operation from IDLE or DONE; checks busy for W cycles then result
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] exp_r, input logic exp_bo, input string name);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = 4'hF; b = 4'hF;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s_busy[%0d] got busy=%b done=%b want 1 0", name, i, busy, done); else passed++;
      tick();
    end
    checks++; if (done !== 1'b1) $display("FAIL %s_done got %b want 1", name, done); else passed++;
    checks++; if (result !== exp_r) $display("FAIL %s_result got %h want %h", name, result, exp_r); else passed++;
    checks++; if (borrow_out !== exp_bo) $display("FAIL %s_borrow_out got %b want %b", name, borrow_out, exp_bo); else passed++;
  endtask

  task automatic test_vectors();
    run_op(4'd3, 4'd9, 4'hA, 1'b1, "sub_3_9");
    for (int i = 0; i < 3; i++) tick();
    checks++; if (done !== 1'b1 || result !== 4'hA || borrow_out !== 1'b1)
      $display("FAIL hold_done got done=%b result=%h bo=%b want 1 a 1", done, result, borrow_out); else passed++;
    run_op(4'd5, 4'd5, 4'd0, 1'b0, "sub_5_5");
    run_op(4'd0, 4'd15, 4'd1, 1'b1, "sub_0_15");
    run_op(4'd15, 4'd0, 4'd15, 1'b0, "sub_15_0");
  endtask

  task automatic test_start_ignored();
    a = 4'd12; b = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd1; b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (done !== 1'b1) $display("FAIL ignore_done got %b want 1", done); else passed++;
    checks++; if (result !== 4'd8) $display("FAIL ignore_result got %h want 8", result); else passed++;
    checks++; if (borrow_out !== 1'b0) $display("FAIL ignore_borrow_out got %b want 0", borrow_out); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    a = 4'd3; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done); else passed++;
    checks++; if (result !== 4'd0 || borrow_out !== 1'b0)
      $display("FAIL midrst_result got %h/%b want 0/0", result, borrow_out); else passed++;
    run_op(4'd7, 4'd1, 4'd6, 1'b0, "sub_7_1");
  endtask

  task automatic test_back_to_back();
    // Currently in DONE from 7 - 1
    checks++; if (done !== 1'b1) $display("FAIL b2b_pre_done got %b want 1", done); else passed++;
    a = 4'd2; b = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_restart got done=%b busy=%b want 0 1", done, busy); else passed++;
    tick(); tick(); tick();
    checks++; if (done !== 1'b0) $display("FAIL b2b_early got %b want 0", done); else passed++;
    tick();
    checks++; if (done !== 1'b1 || result !== 4'd1 || borrow_out !== 1'b0)
      $display("FAIL b2b_result got done=%b result=%h bo=%b want 1 1 0", done, result, borrow_out); else passed++;
    // Reset wins over start at the same edge
    rst = 1'b0; start = 1'b1; a = 4'd9; b = 4'd3;
    tick();
    rst = 1'b1; start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd0)
      $display("FAIL rst_vs_start got busy=%b done=%b result=%h want 0 0 0", busy, done, result); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rst_vs_start_idle got %b want 0", busy); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    test_reset();
    test_bit_sequence();
    test_vectors();
    test_start_ignored();
    test_reset_mid_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
